multicycle_core: RTL

// Parametrised multi-cycle RV32I-subset core; successor to the single-cycle top.

---
 rtl/multicycle_core.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV32I-subset core with a single shared memory port.
// Instructions step through FETCH/DECODE/EXECUTE/MEM/WB. Memory transfers use a
// req/ready handshake, so fetch and data accesses tolerate any latency.
module multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  a0,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam int NREGS = 1 << REG_AW;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0]  pc, ir, rs1_val, rs2_val, imm, result, addr;
  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] instret_cnt;

  // Word-align an address: PC and data addresses never carry byte offsets.
  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], 2'b00};
  endfunction

  // Instruction fields; the register-index MSBs above REG_AW are ignored.
  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign rs1_idx = ir[15 +: REG_AW];
  assign rs2_idx = ir[20 +: REG_AW];
  assign rd_idx  = ir[7 +: REG_AW];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  // Instruction classes recognised by this core; anything else halts it.
  logic is_alu, is_addi, is_lui, is_lw, is_sw, is_jal, is_br, br_taken;

  assign is_alu  = (opcode == OP_OP) && (funct3 == 3'b000) &&
                   ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
  assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
  assign is_lui  = (opcode == OP_LUI);
  assign is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
  assign is_sw   = (opcode == OP_STORE)  && (funct3 == 3'b010);
  assign is_jal  = (opcode == OP_JAL);
  assign is_br   = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
  // funct3[0] selects BNE (1) versus BEQ (0).
  assign br_taken = funct3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val);

  assign a0      = regs[10];
  assign halted  = (state == S_HALT);
  assign instret = instret_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Next-state logic; memory waits hold the current state until ready.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (mem_ready) state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (is_alu || is_addi || is_lui || is_jal) state_next = S_WB;
        else if (is_lw || is_sw)                   state_next = S_MEM;
        else if (is_br)                            state_next = S_FETCH;
        else                                       state_next = S_HALT;
      end
      S_MEM:     if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
      S_WB:      state_next = S_FETCH;
      default:   state_next = S_HALT;
    endcase
  end

  // Memory port outputs; request is masked while reset is held so the bus goes idle at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = rs2_val;
    case (state)
      S_FETCH: mem_req = 1'b1;
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = addr;
      end
      default: ;
    endcase
    if (!rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Datapath: PC, IR, operand latches, register file and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= align(PC_RESET);
      ir          <= '0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      imm         <= '0;
      result      <= '0;
      addr        <= '0;
      instret_cnt <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          rs1_val <= regs[rs1_idx];
          rs2_val <= regs[rs2_idx];
          case (opcode)
            OP_STORE:  imm <= imm_s;
            OP_BRANCH: imm <= imm_b;
            OP_LUI:    imm <= imm_u;
            OP_JAL:    imm <= imm_j;
            default:   imm <= imm_i;
          endcase
        end
        S_EXECUTE: begin
          if (is_alu)             result <= funct7[5] ? rs1_val - rs2_val : rs1_val + rs2_val;
          else if (is_addi)       result <= rs1_val + imm;
          else if (is_lui)        result <= imm;
          else if (is_jal)        result <= pc + XLEN'(4);
          else if (is_lw || is_sw) addr  <= align(rs1_val + imm);
          else if (is_br) begin
            pc          <= align(br_taken ? pc + imm : pc + XLEN'(4));
            instret_cnt <= instret_cnt + CNT_W'(1);
          end
        end
        S_MEM: if (mem_ready) begin
          if (is_lw) result <= mem_rdata;
          else begin
            pc          <= align(pc + XLEN'(4));
            instret_cnt <= instret_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          if (rd_idx != '0) regs[rd_idx] <= result;
          pc          <= align(is_jal ? pc + imm : pc + XLEN'(4));
          instret_cnt <= instret_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
